// File: rtl/updown_counter_bcd_pkg.sv
// updown_counter_bcd shared definitions: 7-seg patterns, direction codes,
// count operation encoding and the constant BCD encoder.
package updown_counter_bcd_pkg;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  typedef enum logic [1:0] {
    OP_HOLD,
    OP_CLEAR,
    OP_UP,
    OP_DOWN
  } op_e;

  // Packs up to four decimal digits, LSD in [3:0].
  function automatic logic [15:0] to_bcd(input int unsigned v);
    logic [15:0] r;
    int unsigned t;
    r = '0;
    t = v;
    for (int d = 0; d < 4; d++) begin
      r[4*d +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

endpackage

// File: rtl/updown_counter_bcd_seg7_dec.sv
// seg7_dec: one BCD digit to active-low {g..a} segments.
// Codes A-F blank the display.
module seg7_dec
  import updown_counter_bcd_pkg::*;
(
  input  logic [3:0] i_bcd,
  output logic [6:0] o_seg
);

  // Digit pattern lookup.
  always_comb begin
    o_seg = SEG_BLANK;
    unique case (i_bcd)
      4'd0:    o_seg = SEG_0;
      4'd1:    o_seg = SEG_1;
      4'd2:    o_seg = SEG_2;
      4'd3:    o_seg = SEG_3;
      4'd4:    o_seg = SEG_4;
      4'd5:    o_seg = SEG_5;
      4'd6:    o_seg = SEG_6;
      4'd7:    o_seg = SEG_7;
      4'd8:    o_seg = SEG_8;
      4'd9:    o_seg = SEG_9;
      default: o_seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/updown_counter_bcd.sv
// updown_counter_bcd: modulo up/down counter, binary + BCD + 7-seg.
// Define COUNTER_SAT_EN to saturate at 0 / MAX_VAL instead of wrapping.
module updown_counter_bcd
  import updown_counter_bcd_pkg::*;
#(
  parameter int DIGITS  = 2,
  parameter int MAX_VAL = 99,
  parameter int CW      = 7
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  up_down,
  input  logic                  clear,
  output logic [CW-1:0]         count,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [7*DIGITS-1:0]   hex,
  output logic                  wrap
);

  localparam logic [CW-1:0] LP_MAX = CW'(MAX_VAL);
  localparam logic [15:0]   LP_MAX_BCD16 = to_bcd(MAX_VAL);
  localparam logic [4*DIGITS-1:0] LP_MAX_BCD =
    LP_MAX_BCD16[4*DIGITS-1:0];

  logic [CW-1:0]       r_count;
  logic [4*DIGITS-1:0] r_bcd;
  logic                r_wrap;

  op_e                 w_op;
  logic                w_at_max;
  logic                w_at_zero;
  logic [4*DIGITS-1:0] w_bcd_inc;
  logic [4*DIGITS-1:0] w_bcd_dec;
  logic [CW-1:0]       w_count_nxt;
  logic [4*DIGITS-1:0] w_bcd_nxt;
  logic                w_wrap_nxt;

  assign w_at_max  = (r_count == LP_MAX);
  assign w_at_zero = (r_count == '0);

  // Priority decode: clear, then enable with direction, else hold.
  always_comb begin
    w_op = OP_HOLD;
    unique case (1'b1)
      clear:
        w_op = OP_CLEAR;
      (!clear && enable && up_down == DIR_UP):
        w_op = OP_UP;
      (!clear && enable && up_down == DIR_DOWN):
        w_op = OP_DOWN;
      default:
        w_op = OP_HOLD;
    endcase
  end

  // BCD increment with digit carry chain.
  always_comb begin : p_inc
    logic cy;
    cy = 1'b1;
    w_bcd_inc = r_bcd;
    for (int d = 0; d < DIGITS; d++) begin
      if (cy) begin
        if (r_bcd[4*d +: 4] == 4'd9) begin
          w_bcd_inc[4*d +: 4] = 4'd0;
        end else begin
          w_bcd_inc[4*d +: 4] = r_bcd[4*d +: 4] + 4'd1;
          cy = 1'b0;
        end
      end
    end
  end

  // BCD decrement with digit borrow chain.
  always_comb begin : p_dec
    logic bw;
    bw = 1'b1;
    w_bcd_dec = r_bcd;
    for (int d = 0; d < DIGITS; d++) begin
      if (bw) begin
        if (r_bcd[4*d +: 4] == 4'd0) begin
          w_bcd_dec[4*d +: 4] = 4'd9;
        end else begin
          w_bcd_dec[4*d +: 4] = r_bcd[4*d +: 4] - 4'd1;
          bw = 1'b0;
        end
      end
    end
  end

  // Next count/bcd/wrap, with wrap or saturate at the limits.
  always_comb begin
    w_count_nxt = r_count;
    w_bcd_nxt   = r_bcd;
    w_wrap_nxt  = 1'b0;
    unique case (w_op)
      OP_CLEAR: begin
        w_count_nxt = '0;
        w_bcd_nxt   = '0;
      end
      OP_UP: begin
        if (w_at_max) begin
          w_wrap_nxt  = 1'b1;
`ifndef COUNTER_SAT_EN
          w_count_nxt = '0;
          w_bcd_nxt   = '0;
`endif
        end else begin
          w_count_nxt = r_count + CW'(1);
          w_bcd_nxt   = w_bcd_inc;
        end
      end
      OP_DOWN: begin
        if (w_at_zero) begin
          w_wrap_nxt  = 1'b1;
`ifndef COUNTER_SAT_EN
          w_count_nxt = LP_MAX;
          w_bcd_nxt   = LP_MAX_BCD;
`endif
        end else begin
          w_count_nxt = r_count - CW'(1);
          w_bcd_nxt   = w_bcd_dec;
        end
      end
      default: begin
        w_count_nxt = r_count;
        w_bcd_nxt   = r_bcd;
      end
    endcase
  end

  // Count state registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
      r_bcd   <= '0;
      r_wrap  <= 1'b0;
    end else begin
      r_count <= w_count_nxt;
      r_bcd   <= w_bcd_nxt;
      r_wrap  <= w_wrap_nxt;
    end
  end

  assign count = r_count;
  assign bcd   = r_bcd;
  assign wrap  = r_wrap;

  for (genvar g = 0; g < DIGITS; g++) begin : g_dig
    seg7_dec u_dec (
      .i_bcd (r_bcd[4*g +: 4]),
      .o_seg (hex[7*g +: 7])
    );
  end

endmodule
